ahb_sram_slave: RTL and testbench
=================================

// Module: ahb_sram_slave
// PURPOSE
//  AHB responder for the SRAM_SLAVE decode slot: the completer end of the bus that the CPU/DMA masters drive.
//  Captures address-phase controls, services the data phase from on-chip word memory, inserts configurable wait
//  states, and returns OKAY or the two-cycle ERROR response. Sits behind the interconnect decoder/HREADY mux.
// PARAMETERS
//  DATA_WIDTH   32    HRDATA/HWDATA width (32 only; byte lanes = DATA_WIDTH/8)
//  ADDR_WIDTH   32    HADDR width
//  MEM_WORDS    1024  memory depth in words; word index = HADDR[ADDR_WIDTH-1:2]
//  WAIT_STATES  0     HREADYOUT-low cycles inserted per OKAY transfer (0..15)
//  RO_WORDS     16    read-only region size in words from index 0 (used only with macro)
// PORTS
//  HCLK       in   1           bus clock, all state on rising edge
//  HRESET     in   1           synchronous reset, active-high
//  HSEL       in   1           slave select from decoder
//  HADDR      in   ADDR_WIDTH  byte address
//  HTRANS     in   2           htrans_t IDLE/BUSY/NONSEQ/SEQ
//  HWRITE     in   1           1 = write
//  HSIZE      in   3           hsize_t BYTE/HALF_WORD/WORD
//  HBURST     in   3           hburst_t; informational, not checked
//  HWDATA     in   DATA_WIDTH  write data, valid in data phase
//  HREADY     in   1           bus-wide ready from HREADY mux
//  HRDATA     out  DATA_WIDTH  read data, registered
//  HREADYOUT  out  1           this slave's ready
//  HRESP      out  2           hresp_t OKAY/ERROR only (RETRY/SPLIT never issued)
// BEHAVIOUR
//  - Reset (sync, HRESET=1): state IDLE, HREADYOUT=1, HRESP=OKAY, HRDATA=0, wait counter 0; memory NOT cleared.
//    Reset mid-transfer aborts it; a pending write is dropped.
//  - Address phase accepted when HSEL & HREADY & HTRANS[1]; addr/size/write registered. IDLE/BUSY or HSEL=0:
//    zero-wait OKAY, no memory access.
//  - Error check at acceptance: word index >= MEM_WORDS; HSIZE>WORD; HALF_WORD with HADDR[0]=1;
//    WORD with HADDR[1:0]!=0. Error has priority over wait states.
//  - FSM: IDLE -> (accepted ok, WAIT_STATES>0) WAIT -> DATA; IDLE -> (ok, WAIT_STATES=0) DATA;
//    IDLE -> (error) ERR1 -> ERR2 -> IDLE/next. DATA with new accepted phase restarts the same decision.
//  - WAIT: HREADYOUT=0, HRESP=OKAY, counter counts WAIT_STATES cycles, then DATA.
//  - DATA: HREADYOUT=1, HRESP=OKAY; write: HWDATA byte lanes selected by HSIZE/HADDR[1:0] written at cycle end.
//  - ERR1: HREADYOUT=0, HRESP=ERROR. ERR2: HREADYOUT=1, HRESP=ERROR. No memory write; HRDATA held.
//  - Read: HRDATA loaded at the edge entering the final (HREADYOUT=1) data cycle; a write completing at that
//    same edge to the same word is forwarded (merged bytes). Unselected lanes return memory contents.
//  - Back-to-back pipelined transfers (incl. bursts) at WAIT_STATES=0 sustain one transfer per cycle.
//  - New address phase with HREADY=0 (other slave stalling) is ignored; master must hold it.
// CONFIGURATION
//  AHB_SRAM_RO_REGION_EN defined: writes to word index < RO_WORDS take two-cycle ERROR, memory unchanged;
//    reads there are normal OKAY.
//  Undefined: RO_WORDS ignored; all in-range writes allowed.
// TESTING
//  1 Reset: HRESET=1 two cycles -> HREADYOUT=1, HRESP=OKAY, HRDATA=0; prior mem content survives.
//  2 WORD write 0xDEADBEEF @0x40 then WORD read @0x40, WAIT_STATES=0 -> read HRDATA=0xDEADBEEF, no wait cycles.
//  3 BYTE write 0xAA @0x43 over 0x11223344 -> word reads 0xAA223344 (forwarded when back-to-back).
//  4 WAIT_STATES=2, INCR4 read @0x100 -> each beat 2 HREADYOUT=0 cycles, then data; 12 cycles total.
//  5 WORD read @0x2 (misaligned) and @MEM_WORDS*4 -> ERR1 (HREADYOUT=0,ERROR), ERR2 (1,ERROR); no mem change.
//  6 With AHB_SRAM_RO_REGION_EN, write 0x5 @0x0 -> ERROR pair, readback unchanged; without macro -> OKAY, reads 0x5.

Source files
------------

// File: rtl/ahb_sram_slave_if.sv
// AHB bus bundle between an interconnect-side master and the SRAM responder.
interface ahb_sram_slave_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  HSEL;
    logic [ADDR_WIDTH-1:0] HADDR;
    logic [1:0]            HTRANS;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [DATA_WIDTH-1:0] HWDATA;
    logic                  HREADY;
    logic [DATA_WIDTH-1:0] HRDATA;
    logic                  HREADYOUT;
    logic [1:0]            HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB SRAM responder: word memory, configurable wait states, two-cycle ERROR response.
// Define AHB_SRAM_RO_REGION_EN to make word indices below RO_WORDS write-protected.
module ahb_sram_slave #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned MEM_WORDS   = 1024,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned RO_WORDS    = 16
) (
    input  logic            HCLK,
    input  logic            HRESET,
    ahb_sram_slave_if.slave bus
);
    localparam int unsigned IDX_W    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int unsigned WIDX_W   = ADDR_WIDTH - 2;
    localparam int unsigned NB       = DATA_WIDTH / 8;
    localparam logic [3:0]  CNT_LAST = 4'(WAIT_STATES - 1);
`ifdef AHB_SRAM_RO_REGION_EN
    localparam bit RO_EN = 1'b1;
`else
    localparam bit RO_EN = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_e;
    typedef enum logic [1:0] {RESP_OKAY = 2'b00, RESP_ERROR = 2'b01} hresp_e;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q;
    logic [1:0]            ofs_q;
    logic [1:0]            size_q;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] hrdata_q;
    logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

    logic                  ready;
    hresp_e                resp;
    logic                  accept;
    logic                  acc_err;
    logic                  wr_en;
    logic                  rd_load;
    logic [WIDX_W-1:0]     word_idx;
    logic [IDX_W-1:0]      addr_idx;
    logic [IDX_W-1:0]      rd_idx;
    logic [NB-1:0]         lanes;
    logic [DATA_WIDTH-1:0] wr_word;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  unused_ok;

    assign word_idx  = bus.HADDR[ADDR_WIDTH-1:2];
    assign addr_idx  = bus.HADDR[IDX_W+1:2];
    assign accept    = bus.HSEL && bus.HREADY && bus.HTRANS[1] && ready;
    assign unused_ok = ^{bus.HBURST, bus.HTRANS[0]};

    always_comb begin
        acc_err = 1'b0;
        if (word_idx >= WIDX_W'(MEM_WORDS))                    acc_err = 1'b1;
        if (bus.HSIZE > 3'd2)                                  acc_err = 1'b1;
        if (bus.HSIZE == 3'd1 && bus.HADDR[0])                 acc_err = 1'b1;
        if (bus.HSIZE == 3'd2 && bus.HADDR[1:0] != 2'b00)      acc_err = 1'b1;
        if (RO_EN && bus.HWRITE && word_idx < WIDX_W'(RO_WORDS)) acc_err = 1'b1;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // IDLE, DATA and ERR2 all drive HREADYOUT high, so each may take a new address phase.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_ERR1:  state_d = S_ERR2;
            default: begin
                if (!accept)            state_d = S_IDLE;
                else if (acc_err)       state_d = S_ERR1;
                else if (WAIT_STATES > 0) state_d = S_WAIT;
                else                    state_d = S_DATA;
            end
        endcase
    end

    always_comb begin
        ready = 1'b1;
        resp  = RESP_OKAY;
        case (state_q)
            S_WAIT: ready = 1'b0;
            S_ERR1: begin
                ready = 1'b0;
                resp  = RESP_ERROR;
            end
            S_ERR2: resp = RESP_ERROR;
            default: ;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            idx_q   <= '0;
            ofs_q   <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
        end else if (accept) begin
            idx_q   <= addr_idx;
            ofs_q   <= bus.HADDR[1:0];
            size_q  <= bus.HSIZE[1:0];
            write_q <= bus.HWRITE;
        end
    end

    always_comb begin
        lanes = '0;
        case (size_q)
            2'd0:    lanes[ofs_q] = 1'b1;
            2'd1:    lanes[{ofs_q[1], 1'b0} +: 2] = 2'b11;
            default: lanes = '1;
        endcase
    end

    assign wr_en = (state_q == S_DATA) && write_q;

    always_comb begin
        wr_word = mem_q[idx_q];
        for (int unsigned b = 0; b < NB; b++) begin
            if (lanes[b]) wr_word[8*b +: 8] = bus.HWDATA[8*b +: 8];
        end
    end

    // Read target is the registered phase when leaving WAIT, otherwise the phase being accepted;
    // a write retiring on the same edge to the same word is forwarded.
    always_comb begin
        if (state_q == S_WAIT) begin
            rd_idx  = idx_q;
            rd_load = (state_d == S_DATA) && !write_q;
        end else begin
            rd_idx  = addr_idx;
            rd_load = (state_d == S_DATA) && !bus.HWRITE;
        end
        rd_word = (wr_en && idx_q == rd_idx) ? wr_word : mem_q[rd_idx];
    end

    always_ff @(posedge HCLK) begin
        if (HRESET)       hrdata_q <= '0;
        else if (rd_load) hrdata_q <= rd_word;
    end

    always_ff @(posedge HCLK) begin
        if (!HRESET && wr_en) mem_q[idx_q] <= wr_word;
    end

    assign bus.HRDATA    = hrdata_q;
    assign bus.HREADYOUT = ready;
    assign bus.HRESP     = resp;
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Scoreboard bench: two responders (0 and 2 wait states) behind a modelled HREADY mux.
module tb_ahb_sram_slave;
    localparam logic [2:0] SZ_B  = 3'd0;
    localparam logic [2:0] SZ_H  = 3'd1;
    localparam logic [2:0] SZ_W  = 3'd2;
    localparam logic [1:0] TR_NS = 2'b10;
    localparam logic [1:0] TR_SQ = 2'b11;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ahb_sram_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus0 ();
    ahb_sram_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus1 ();

    ahb_sram_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_WORDS(1024), .WAIT_STATES(0), .RO_WORDS(16))
        dut0 (.HCLK(clk), .HRESET(rst), .bus(bus0));
    ahb_sram_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_WORDS(1024), .WAIT_STATES(2), .RO_WORDS(16))
        dut1 (.HCLK(clk), .HRESET(rst), .bus(bus1));

    logic        which;
    logic        s_hsel;
    logic [31:0] s_haddr;
    logic [1:0]  s_htrans;
    logic        s_hwrite;
    logic [2:0]  s_hsize;
    logic [2:0]  s_hburst;
    logic [31:0] s_hwdata;
    logic        m_ready;
    logic [31:0] m_rdata;
    logic [1:0]  m_resp;

    assign m_ready = which ? bus1.HREADYOUT : bus0.HREADYOUT;
    assign m_rdata = which ? bus1.HRDATA    : bus0.HRDATA;
    assign m_resp  = which ? bus1.HRESP     : bus0.HRESP;

    assign bus0.HSEL   = s_hsel & ~which;
    assign bus1.HSEL   = s_hsel & which;
    assign bus0.HADDR  = s_haddr;  assign bus1.HADDR  = s_haddr;
    assign bus0.HTRANS = s_htrans; assign bus1.HTRANS = s_htrans;
    assign bus0.HWRITE = s_hwrite; assign bus1.HWRITE = s_hwrite;
    assign bus0.HSIZE  = s_hsize;  assign bus1.HSIZE  = s_hsize;
    assign bus0.HBURST = s_hburst; assign bus1.HBURST = s_hburst;
    assign bus0.HWDATA = s_hwdata; assign bus1.HWDATA = s_hwdata;
    assign bus0.HREADY = m_ready;  assign bus1.HREADY = m_ready;

    typedef struct {
        logic [31:0] addr;
        bit          wr;
        logic [2:0]  size;
        logic [1:0]  trans;
        logic [31:0] wdata;
        bit          err;
        bit          chk;
        logic [31:0] rdata;
    } xfer_t;

    typedef struct {
        bit          rd;
        bit          chk;
        logic [31:0] rdata;
        bit          err;
        int          waits;
    } exp_t;

    xfer_t q[$];
    exp_t  sb[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [31:0] a, input bit wr, input logic [2:0] sz, input logic [1:0] tr,
                       input logic [31:0] wd, input bit err, input bit chk, input logic [31:0] rd);
        xfer_t x;
        x.addr = a; x.wr = wr; x.size = sz; x.trans = tr;
        x.wdata = wd; x.err = err; x.chk = chk; x.rdata = rd;
        q.push_back(x);
    endtask

    // Pipelined master: address of item i overlaps the data phase of item i-1.
    task automatic run(input int ws, output int cycles);
        int   n;
        bit   ok;
        exp_t e;
        cycles = 0;
        for (int i = 0; i <= q.size(); i++) begin
            if (i < q.size()) begin
                s_hsel = 1'b1; s_haddr = q[i].addr; s_htrans = q[i].trans;
                s_hwrite = q[i].wr; s_hsize = q[i].size;
            end else begin
                s_hsel = 1'b0; s_htrans = 2'b00; s_hwrite = 1'b0;
            end
            if (i > 0) s_hwdata = q[i-1].wdata;
            n = 0;
            ok = 1'b0;
            while (!ok && n < 40) begin
                @(negedge clk);
                ok = m_ready;
                @(posedge clk);
                #1;
                n++;
            end
            if (!ok) begin
                n_checks++;
                n_errors++;
                $display("FAIL hready_timeout: got stalled 40 cycles expected acceptance (item %0d)", i);
            end
            if (i > 0) cycles += n;
            if (i < q.size()) begin
                e.rd = !q[i].wr; e.chk = q[i].chk; e.rdata = q[i].rdata;
                e.err = q[i].err; e.waits = q[i].err ? 1 : ws;
                sb.push_back(e);
            end
        end
        q.delete();
    endtask

    task automatic do_reset();
        s_hsel = 1'b0;
        s_htrans = 2'b00;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hreadyout0", 32'(bus0.HREADYOUT), 32'd1);
        check("rst_hresp0",     32'(bus0.HRESP),     32'd0);
        check("rst_hrdata0",    bus0.HRDATA,         32'd0);
        check("rst_hreadyout1", 32'(bus1.HREADYOUT), 32'd1);
        check("rst_hresp1",     32'(bus1.HRESP),     32'd0);
        check("rst_hrdata1",    bus1.HRDATA,         32'd0);
        rst = 1'b0;
    endtask

    initial begin : monitor
        bit          pending;
        int          waits;
        logic [1:0]  low_resp;
        exp_t        e;
        pending = 1'b0;
        waits = 0;
        low_resp = 2'b00;
        forever begin
            @(negedge clk);
            if (rst) begin
                pending = 1'b0;
                waits = 0;
            end else begin
                if (pending) begin
                    if (!m_ready) begin
                        waits++;
                        low_resp = m_resp;
                    end else begin
                        if (sb.size() == 0) begin
                            n_checks++;
                            n_errors++;
                            $display("FAIL sb_underflow: got completion expected none at %0t", $time);
                        end else begin
                            e = sb.pop_front();
                            check("hresp", 32'(m_resp), 32'(e.err));
                            check("wait_cycles", 32'(waits), 32'(e.waits));
                            if (waits > 0) check("hresp_stall", 32'(low_resp), 32'(e.err));
                            if (e.rd && e.chk && !e.err) check("hrdata", m_rdata, e.rdata);
                        end
                        pending = 1'b0;
                        waits = 0;
                    end
                end
                if (s_hsel && m_ready && s_htrans[1]) begin
                    pending = 1'b1;
                    waits = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish by 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        which = 1'b0; s_hsel = 1'b0; s_haddr = '0; s_htrans = 2'b00; s_hwrite = 1'b0;
        s_hsize = SZ_W; s_hburst = 3'b000; s_hwdata = '0; rst = 1'b1;
        do_reset();

        // Memory survives reset while HRDATA clears
        add(32'h80, 1, SZ_W, TR_NS, 32'hCAFEF00D, 0, 0, 0);
        add(32'h80, 0, SZ_W, TR_NS, 32'h0,        0, 1, 32'hCAFEF00D);
        run(0, cyc);
        do_reset();
        add(32'h80, 0, SZ_W, TR_NS, 32'h0, 0, 1, 32'hCAFEF00D);
        run(0, cyc);

        // Word write then forwarded read, then a plain read
        add(32'h40, 1, SZ_W, TR_NS, 32'hDEADBEEF, 0, 0, 0);
        add(32'h40, 0, SZ_W, TR_NS, 32'h0,        0, 1, 32'hDEADBEEF);
        add(32'h44, 1, SZ_W, TR_NS, 32'h0BADF00D, 0, 0, 0);
        add(32'h40, 0, SZ_W, TR_NS, 32'h0,        0, 1, 32'hDEADBEEF);
        run(0, cyc);

        // Sub-word lanes with forwarding
        add(32'h40, 1, SZ_W, TR_NS, 32'h11223344, 0, 0, 0);
        add(32'h43, 1, SZ_B, TR_NS, 32'hAA000000, 0, 0, 0);
        add(32'h40, 0, SZ_W, TR_NS, 32'h0,        0, 1, 32'hAA223344);
        add(32'h42, 1, SZ_H, TR_NS, 32'h55660000, 0, 0, 0);
        add(32'h41, 1, SZ_B, TR_NS, 32'h0000BB00, 0, 0, 0);
        add(32'h40, 0, SZ_W, TR_NS, 32'h0,        0, 1, 32'h5566BB44);
        run(0, cyc);

        // Error responses; memory untouched by the rejected write
        add(32'h2,    0, SZ_W,  TR_NS, 32'h0,        1, 0, 0);
        add(32'h1000, 0, SZ_W,  TR_NS, 32'h0,        1, 0, 0);
        add(32'h41,   0, SZ_H,  TR_NS, 32'h0,        1, 0, 0);
        add(32'h0,    0, 3'd3,  TR_NS, 32'h0,        1, 0, 0);
        add(32'h42,   1, SZ_W,  TR_NS, 32'h12345678, 1, 0, 0);
        add(32'h40,   0, SZ_W,  TR_NS, 32'h0,        0, 1, 32'h5566BB44);
        add(32'hFFC,  0, SZ_W,  TR_NS, 32'h0,        0, 0, 0);
        run(0, cyc);

`ifdef AHB_SRAM_RO_REGION_EN
        add(32'h0,  1, SZ_W, TR_NS, 32'h5, 1, 0, 0);
        add(32'h0,  0, SZ_W, TR_NS, 32'h0, 0, 0, 0);
        add(32'h3C, 1, SZ_W, TR_NS, 32'h7, 1, 0, 0);
        run(0, cyc);
`else
        add(32'h0, 1, SZ_W, TR_NS, 32'h5, 0, 0, 0);
        add(32'h0, 0, SZ_W, TR_NS, 32'h0, 0, 1, 32'h5);
        run(0, cyc);
`endif

        // INCR4 at zero wait states: one beat per cycle
        s_hburst = 3'b011;
        add(32'h200, 1, SZ_W, TR_NS, 32'hB0, 0, 0, 0);
        add(32'h204, 1, SZ_W, TR_SQ, 32'hB1, 0, 0, 0);
        add(32'h208, 1, SZ_W, TR_SQ, 32'hB2, 0, 0, 0);
        add(32'h20C, 1, SZ_W, TR_SQ, 32'hB3, 0, 0, 0);
        run(0, cyc);
        check("ws0_wr_burst_cycles", 32'(cyc), 32'd4);
        add(32'h200, 0, SZ_W, TR_NS, 32'h0, 0, 1, 32'hB0);
        add(32'h204, 0, SZ_W, TR_SQ, 32'h0, 0, 1, 32'hB1);
        add(32'h208, 0, SZ_W, TR_SQ, 32'h0, 0, 1, 32'hB2);
        add(32'h20C, 0, SZ_W, TR_SQ, 32'h0, 0, 1, 32'hB3);
        run(0, cyc);
        check("ws0_rd_burst_cycles", 32'(cyc), 32'd4);

        // Two wait states per beat on the second responder
        which = 1'b1;
        add(32'h100, 1, SZ_W, TR_NS, 32'hA0, 0, 0, 0);
        add(32'h104, 1, SZ_W, TR_SQ, 32'hA1, 0, 0, 0);
        add(32'h108, 1, SZ_W, TR_SQ, 32'hA2, 0, 0, 0);
        add(32'h10C, 1, SZ_W, TR_SQ, 32'hA3, 0, 0, 0);
        run(2, cyc);
        check("ws2_wr_burst_cycles", 32'(cyc), 32'd12);
        add(32'h100, 0, SZ_W, TR_NS, 32'h0, 0, 1, 32'hA0);
        add(32'h104, 0, SZ_W, TR_SQ, 32'h0, 0, 1, 32'hA1);
        add(32'h108, 0, SZ_W, TR_SQ, 32'h0, 0, 1, 32'hA2);
        add(32'h10C, 0, SZ_W, TR_SQ, 32'h0, 0, 1, 32'hA3);
        run(2, cyc);
        check("ws2_rd_burst_cycles", 32'(cyc), 32'd12);
        s_hburst = 3'b000;
        add(32'h6, 0, SZ_W, TR_NS, 32'h0, 1, 0, 0);
        add(32'h104, 0, SZ_W, TR_NS, 32'h0, 0, 1, 32'hA1);
        run(2, cyc);

        repeat (4) @(posedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
